// File: rtl/notebank_pkg.sv
// ============================================================================
// Module      : notebank_pkg
// Description : Shared types, constants and the output saturation helper
//               for the polyphonic note bank.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package notebank_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } voice_state_t;

    // Clamp a wide signed value into the range of a WIDTH-bit signed number.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] x,
        input int unsigned        width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/notebank_voice.sv
// ============================================================================
// Module      : notebank_voice
// Description : One voice: note latch FSM, phase counter, PWM compare and
//               amplitude envelope. Ramped envelope when
//               POLY_NOTEBANK_ENVELOPE_EN is defined, gated on/off otherwise.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module notebank_voice
    import notebank_pkg::*;
#(
    parameter int PERIOD_W = 23,
    parameter int AMP_W    = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_on,
    input  logic                    note_off,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [DUTY_W-1:0]       duty,
    input  logic [AMP_W-1:0]        amp,
    input  logic [AMP_W-1:0]        att_step,
    input  logic [AMP_W-1:0]        rel_step,
    input  logic                    sample_en,
    output logic signed [AMP_W:0]   sample,
    output logic                    active,
    output logic                    done
);

    localparam int PROD_W = PERIOD_W + DUTY_W;

    voice_state_t           r_state;
    voice_state_t           w_state_nxt;
    logic [AMP_W-1:0]       r_env;
    logic [AMP_W-1:0]       w_env_nxt;
    logic [PERIOD_W-1:0]    r_phase;
    logic [PERIOD_W-1:0]    w_phase_nxt;
    logic [PERIOD_W-1:0]    r_period;
    logic [PERIOD_W-1:0]    r_thr;
    logic [PERIOD_W-1:0]    w_thr;
    logic                   r_active;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_capture;

    assign w_thr = PERIOD_W'((PROD_W'(period) * PROD_W'(duty)) >> DUTY_W);

`ifdef POLY_NOTEBANK_ENVELOPE_EN
    logic [AMP_W:0] w_att_sum;
    assign w_att_sum = {1'b0, r_env} + {1'b0, att_step};
`else
    logic w_unused;
    assign w_unused = ^{att_step, rel_step, sample_en};
`endif

    // note_on has priority over note_off in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        if (note_on) begin
            w_capture   = 1'b1;
`ifdef POLY_NOTEBANK_ENVELOPE_EN
            w_state_nxt = ST_ATTACK;
`else
            w_state_nxt = ST_SUSTAIN;
            w_env_nxt   = amp;
`endif
        end else begin
            case (r_state)
`ifdef POLY_NOTEBANK_ENVELOPE_EN
                ST_ATTACK: begin
                    if (note_off) begin
                        w_state_nxt = ST_RELEASE;
                    end else if (sample_en) begin
                        if (w_att_sum >= {1'b0, amp}) begin
                            w_env_nxt   = amp;
                            w_state_nxt = ST_SUSTAIN;
                        end else begin
                            w_env_nxt = w_att_sum[AMP_W-1:0];
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (note_off) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_env_nxt = amp;
                    end
                end
                ST_RELEASE: begin
                    if (sample_en) begin
                        if (r_env <= rel_step) begin
                            w_env_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_env_nxt = r_env - rel_step;
                        end
                    end
                end
`else
                ST_SUSTAIN: begin
                    if (note_off) begin
                        w_env_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_env_nxt = amp;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Degenerate periods (0 or 1) pin the phase at zero.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_capture || (r_state == ST_IDLE)) begin
            w_phase_nxt = '0;
        end else if ((r_period < PERIOD_W'(2)) || (r_phase >= r_period - PERIOD_W'(1))) begin
            w_phase_nxt = '0;
        end else begin
            w_phase_nxt = r_phase + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_env    <= '0;
            r_phase  <= '0;
            r_period <= '0;
            r_thr    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_env    <= w_env_nxt;
            r_phase  <= w_phase_nxt;
            r_active <= (w_state_nxt != ST_IDLE);
            r_done   <= w_done_nxt;
            if (w_capture) begin
                r_period <= period;
                r_thr    <= w_thr;
            end
        end
    end

    always_comb begin
        sample = '0;
        if (r_state != ST_IDLE) begin
            sample = (r_phase < r_thr) ? $signed({1'b0, r_env}) : -$signed({1'b0, r_env});
        end
    end

    assign active = r_active;
    assign done   = r_done;

endmodule

`default_nettype wire

// File: rtl/poly_notebank.sv
// ============================================================================
// Module      : poly_notebank
// Description : VOICES-voice PWM note bank with saturating signed mixer.
//               Envelope ramps enabled by POLY_NOTEBANK_ENVELOPE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module poly_notebank
    import notebank_pkg::*;
#(
    parameter int VOICES   = 4,
    parameter int PERIOD_W = 23,
    parameter int AMP_W    = 18,
    parameter int OUT_W    = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VOICES-1:0]             note_on,
    input  logic [VOICES-1:0]             note_off,
    input  logic [VOICES*PERIOD_W-1:0]    period,
    input  logic [VOICES*DUTY_W-1:0]      duty,
    input  logic [AMP_W-1:0]              amp,
    input  logic [AMP_W-1:0]              att_step,
    input  logic [AMP_W-1:0]              rel_step,
    input  logic                          sample_en,
    output logic signed [OUT_W-1:0]       audio_out,
    output logic [VOICES-1:0]             done,
    output logic [VOICES-1:0]             active
);

    localparam int SHIFT = OUT_W - AMP_W - 1;

    logic signed [AMP_W:0]     w_sample [VOICES];
    logic signed [63:0]        w_sum;
    logic signed [63:0]        w_scaled;
    logic signed [OUT_W-1:0]   w_sat;
    logic signed [OUT_W-1:0]   r_audio;

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
            notebank_voice #(
                .PERIOD_W (PERIOD_W),
                .AMP_W    (AMP_W)
            ) u_voice (
                .clk       (clk),
                .rst       (rst),
                .note_on   (note_on[gi]),
                .note_off  (note_off[gi]),
                .period    (period[gi*PERIOD_W +: PERIOD_W]),
                .duty      (duty[gi*DUTY_W +: DUTY_W]),
                .amp       (amp),
                .att_step  (att_step),
                .rel_step  (rel_step),
                .sample_en (sample_en),
                .sample    (w_sample[gi]),
                .active    (active[gi]),
                .done      (done[gi])
            );
        end
    endgenerate

    // 64-bit accumulator is wide enough for 16 full-scale voices after scaling.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            w_sum = w_sum + $signed({{(63-AMP_W){w_sample[i][AMP_W]}}, w_sample[i]});
        end
        w_scaled = w_sum <<< SHIFT;
    end

    assign w_sat = OUT_W'(sat_signed(w_scaled, OUT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_audio <= '0;
        end else begin
            r_audio <= w_sat;
        end
    end

    assign audio_out = r_audio;

endmodule

`default_nettype wire

// File: tb/tb_poly_notebank.sv
// ============================================================================
// Module      : tb_poly_notebank
// Description : Directed bench with a cycle-level behavioural model and
//               hand-computed audio/done/active expectations.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_poly_notebank;

    localparam int VOICES   = 4;
    localparam int PERIOD_W = 23;
    localparam int AMP_W    = 18;
    localparam int OUT_W    = 24;

    logic                          clk;
    logic                          rst;
    logic [VOICES-1:0]             note_on;
    logic [VOICES-1:0]             note_off;
    logic [VOICES*PERIOD_W-1:0]    period;
    logic [VOICES*8-1:0]           duty;
    logic [AMP_W-1:0]              amp;
    logic [AMP_W-1:0]              att_step;
    logic [AMP_W-1:0]              rel_step;
    logic                          sample_en;
    logic signed [OUT_W-1:0]       audio_out;
    logic [VOICES-1:0]             done;
    logic [VOICES-1:0]             active;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    poly_notebank #(
        .VOICES   (VOICES),
        .PERIOD_W (PERIOD_W),
        .AMP_W    (AMP_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note_on   (note_on),
        .note_off  (note_off),
        .period    (period),
        .duty      (duty),
        .amp       (amp),
        .att_step  (att_step),
        .rel_step  (rel_step),
        .sample_en (sample_en),
        .audio_out (audio_out),
        .done      (done),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: 0 idle, 1 attack, 2 sustain, 3 release.
    int          m_st   [VOICES];
    longint      m_env  [VOICES];
    longint      m_per  [VOICES];
    longint      m_thr  [VOICES];
    longint      m_age  [VOICES];
    longint      m_audio = 0;
    logic [VOICES-1:0] m_done   = '0;
    logic [VOICES-1:0] m_active = '0;

    initial begin
        for (int v = 0; v < VOICES; v++) begin
            m_st[v] = 0; m_env[v] = 0; m_per[v] = 0; m_thr[v] = 0; m_age[v] = 0;
        end
    end

    always @(posedge clk) begin : model
        longint sum, ph, a, hi, lo, am, att, rel;
        am  = longint'(amp);
        att = longint'(att_step);
        rel = longint'(rel_step);
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                m_st[v] = 0; m_env[v] = 0; m_per[v] = 0; m_thr[v] = 0; m_age[v] = 0;
            end
            m_audio  = 0;
            m_done   = '0;
            m_active = '0;
        end else begin
            sum = 0;
            for (int v = 0; v < VOICES; v++) begin
                if (m_st[v] != 0) begin
                    ph  = (m_per[v] < 2) ? 0 : (m_age[v] % m_per[v]);
                    sum = sum + ((ph < m_thr[v]) ? m_env[v] : -m_env[v]);
                end
            end
            a  = sum * (longint'(1) <<< (OUT_W - AMP_W - 1));
            hi = (longint'(1) <<< (OUT_W - 1)) - 1;
            lo = -(longint'(1) <<< (OUT_W - 1));
            m_audio = (a > hi) ? hi : ((a < lo) ? lo : a);
            for (int v = 0; v < VOICES; v++) begin
                m_done[v] = 1'b0;
                if (note_on[v]) begin
                    m_per[v] = longint'(period[v*PERIOD_W +: PERIOD_W]);
                    m_thr[v] = (m_per[v] * longint'(duty[v*8 +: 8])) / 256;
                    m_age[v] = 0;
`ifdef POLY_NOTEBANK_ENVELOPE_EN
                    m_st[v]  = 1;
`else
                    m_st[v]  = 2;
                    m_env[v] = am;
`endif
                end else if (m_st[v] != 0) begin
                    m_age[v] = m_age[v] + 1;
`ifdef POLY_NOTEBANK_ENVELOPE_EN
                    if (m_st[v] == 1) begin
                        if (note_off[v]) m_st[v] = 3;
                        else if (sample_en) begin
                            if (m_env[v] + att >= am) begin
                                m_env[v] = am; m_st[v] = 2;
                            end else m_env[v] = m_env[v] + att;
                        end
                    end else if (m_st[v] == 2) begin
                        if (note_off[v]) m_st[v] = 3;
                        else m_env[v] = am;
                    end else if (sample_en) begin
                        m_env[v] = m_env[v] - rel;
                        if (m_env[v] <= 0) begin
                            m_env[v] = 0; m_st[v] = 0; m_done[v] = 1'b1;
                        end
                    end
`else
                    if (note_off[v]) begin
                        m_st[v] = 0; m_env[v] = 0; m_done[v] = 1'b1;
                    end else m_env[v] = am;
`endif
                end
                m_active[v] = (m_st[v] != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (audio_out !== OUT_W'(m_audio)) begin
                n_errors++;
                $display("FAIL cyc_audio t=%0t: got %0d expected %0d", $time, audio_out, m_audio);
            end
            n_checks++;
            if (active !== m_active) begin
                n_errors++;
                $display("FAIL cyc_active t=%0t: got %b expected %b", $time, active, m_active);
            end
            n_checks++;
            if (done !== m_done) begin
                n_errors++;
                $display("FAIL cyc_done t=%0t: got %b expected %b", $time, done, m_done);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            note_on  = '0;
            note_off = '0;
        end
    endtask

    task automatic step_env();
        sample_en = 1'b1;
        tick(1);
        sample_en = 1'b0;
        tick(3);
    endtask

    task automatic kill(input logic [VOICES-1:0] mask);
        note_off = mask;
        tick(1);
`ifdef POLY_NOTEBANK_ENVELOPE_EN
        step_env();
`endif
    endtask

    task automatic set_voice(input int v, input int per, input int dt);
        period[v*PERIOD_W +: PERIOD_W] = PERIOD_W'(per);
        duty[v*8 +: 8]                 = 8'(dt);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed sample value.
    task automatic chk_audio(input string name, input longint exp);
        chk({name, "_dut"}, longint'(audio_out), exp);
        chk({name, "_model"}, m_audio, exp);
    endtask

    initial begin
        rst       = 1'b1;
        note_on   = '0;
        note_off  = '0;
        period    = '0;
        duty      = '0;
        amp       = '0;
        att_step  = '0;
        rel_step  = '0;
        sample_en = 1'b0;
        tick(2);
        chk_en = 1'b1;
        chk_audio("reset_audio", 0);
        chk("reset_active", longint'(active), 0);
        chk("reset_done", longint'(done), 0);
        rst = 1'b0;
        tick(1);

`ifndef POLY_NOTEBANK_ENVELOPE_EN
        amp = 18'd1000;
        set_voice(0, 100, 128);
        note_on = 4'b0001;
        tick(1);
        chk("on_active", longint'(active[0]), 1);
        tick(1);
        chk_audio("pwm_high", 32000);
        tick(50);
        chk_audio("pwm_low", -32000);
        tick(10);
        note_off = 4'b0001;
        tick(1);
        chk("off_done", longint'(done[0]), 1);
        chk("off_active", longint'(active[0]), 0);
        tick(1);
        chk("off_done_once", longint'(done[0]), 0);
        chk_audio("off_silent", 0);

        set_voice(1, 0, 200);
        note_on = 4'b0010;
        tick(2);
        chk_audio("period0", -32000);
        set_voice(1, 1, 200);
        note_on = 4'b0010;
        tick(2);
        chk_audio("period1", -32000);
        set_voice(1, 100, 0);
        note_on = 4'b0010;
        tick(2);
        chk_audio("duty0", -32000);
        tick(37);
        chk_audio("duty0_late", -32000);
        kill(4'b0010);
        tick(2);
`else
        amp      = 18'd1000;
        att_step = 18'd300;
        rel_step = 18'd400;
        set_voice(1, 0, 128);
        note_on = 4'b0010;
        tick(1);
        chk("on_active", longint'(active[1]), 1);
        step_env();
        chk_audio("att_300", -9600);
        step_env();
        chk_audio("att_600", -19200);
        step_env();
        chk_audio("att_900", -28800);
        step_env();
        chk_audio("att_1000", -32000);
        note_off = 4'b0010;
        tick(1);
        step_env();
        chk_audio("rel_600", -19200);
        step_env();
        chk_audio("rel_200", -6400);
        step_env();
        chk_audio("rel_0", 0);
        chk("rel_idle", longint'(active[1]), 0);

        att_step = 18'd500;
        note_on  = 4'b0010;
        tick(1);
        step_env();
        chk_audio("retrig_500", -16000);
        note_off = 4'b0010;
        tick(2);
        chk_audio("release_hold", -16000);
        note_on  = 4'b0010;
        note_off = 4'b0010;
        tick(1);
        chk("retrig_active", longint'(active[1]), 1);
        tick(1);
        chk_audio("retrig_keep_env", -16000);
        step_env();
        chk_audio("retrig_reach_amp", -32000);
        kill(4'b0010);
        tick(2);
`endif

        set_voice(3, 0, 128);
        note_on  = 4'b1000;
        note_off = 4'b1000;
        tick(1);
        chk("on_off_idle_active", longint'(active[3]), 1);
        kill(4'b1000);
        tick(2);

        amp      = 18'h3FFFF;
        att_step = 18'h3FFFF;
        for (int v = 0; v < VOICES; v++) set_voice(v, 100, 255);
        note_on = 4'b1111;
        tick(1);
`ifdef POLY_NOTEBANK_ENVELOPE_EN
        step_env();
`else
        tick(1);
`endif
        chk_audio("sat_high", 8388607);
        for (int v = 0; v < VOICES; v++) set_voice(v, 100, 0);
        note_on = 4'b1111;
        tick(2);
        chk_audio("sat_low", -8388608);

        set_voice(2, 100, 128);
        note_on = 4'b0100;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk_audio("rst_audio", 0);
        chk("rst_active", longint'(active), 0);
        chk("rst_done", longint'(done), 0);
        rst = 1'b0;
        tick(3);
        chk_audio("rst_quiet", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/poly_notebank.md
# poly_notebank

Parametrised polyphonic successor to the single-voice note bank. Each of `VOICES` voices has:
- a PWM tone generator;
- a per-voice note on/off latch;
- a linear attack/sustain/release amplitude envelope.

The voices are summed into one saturated signed audio sample. The block sits between the note/MIDI decode logic, which supplies `note_on`, `note_off`, `period` and `duty`, and the audio output path.

## Interface
Parameters:
- `VOICES`, 4: number of voices (1–16).
- `PERIOD_W`, 23: tone period width, in clk cycles.
- `AMP_W`, 18: unsigned envelope/amplitude width.
- `OUT_W`, 24: signed audio output width. Must be ≥ `AMP_W`+2.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `note_on`, in, `VOICES`: per-voice start/retrigger strobe, one cycle.
- `note_off`, in, `VOICES`: per-voice release strobe, one cycle.
- `period`, in, `VOICES*PERIOD_W`: per-voice tone period, packed with voice 0 in the LSBs. Captured at `note_on`.
- `duty`, in, `VOICES*8`: per-voice duty, where 0..255 maps to 0..255/256. Captured at `note_on`.
- `amp`, in, `AMP_W`: shared sustain level. Live input.
- `att_step`, in, `AMP_W`: envelope increment per `sample_en`.
- `rel_step`, in, `AMP_W`: envelope decrement per `sample_en`.
- `sample_en`, in, 1: envelope update tick.
- `audio_out`, out, `OUT_W`: signed mixed sample. Registered.
- `done`, out, `VOICES`: one-cycle pulse when a voice finishes release.
- `active`, out, `VOICES`: voice not IDLE. Registered.

## Operation
- Voice FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
- **IDLE → ATTACK** on `note_on`. Captures:
  - `period`;
  - threshold `thr` = (`period` × `duty`) >> 8;
  - resets `phase` to 0.
- **ATTACK/SUSTAIN → RELEASE** on `note_off`.
- **RELEASE → ATTACK** on `note_on` (retrigger). Recaptures period, duty and `thr`. `env` is kept (no click); `phase` is reset.
- `note_on` and `note_off` in the same cycle: `note_on` wins.
- `note_off` in IDLE: ignored. `note_on` in ATTACK/SUSTAIN: restarts ATTACK with new period/duty and keeps `env`.
- **Phase counter:**
  - Increments every clk while not IDLE; wraps from `period`−1 to 0.
  - If the captured period is < 2, `phase` is held at 0.
  - `sqon` = (`phase` < `thr`).
- **Envelope.** It changes only on cycles with `sample_en`=1, except in SUSTAIN:
  - ATTACK: `env` = min(`env`+`att_step`, `amp`), computed without overflow. Go to SUSTAIN when the result equals `amp`. If `env` > `amp`, clamp to `amp` and go to SUSTAIN.
  - SUSTAIN: `env` = `amp` every clk.
  - RELEASE: `env` = max(`env`−`rel_step`, 0). On reaching 0, go to IDLE and pulse `done`.
  - `rel_step`=0 holds RELEASE indefinitely.
- **Voice sample:** +`env` if `sqon`, else −`env`, as an `AMP_W`+1-bit signed value. IDLE voices contribute 0.
- **Mix:**
  - Full-precision signed sum of all voices.
  - Scale by 2^(`OUT_W`−`AMP_W`−1).
  - Saturate to [−2^(`OUT_W`−1), 2^(`OUT_W`−1)−1].

## Timing
- Reset values:
  - all voices IDLE;
  - `env`, `phase`, `thr` and captured period = 0;
  - `audio_out` = 0, `done` = 0, `active` = 0.
- `rst` asserted mid-note: all of the above are restored on the next edge, and no `done` pulse is emitted.
- `note_on` at edge N: state is ATTACK and `active`=1 after edge N. The first envelope step happens at the first `sample_en` at or after edge N+1.
- `audio_out` latency: 1 clk from the voice registers (`env`, `phase`, state).
- `done`: asserted for exactly the one cycle following the edge where RELEASE → IDLE. `active` deasserts on that same edge.

## Configuration
- `POLY_NOTEBANK_ENVELOPE_EN` defined:
  - ramped envelope exactly as above.
- `POLY_NOTEBANK_ENVELOPE_EN` undefined:
  - `note_on` → SUSTAIN directly, with `env`=`amp`;
  - `note_off` → IDLE, with `env`=0 and `done` pulsed one cycle later;
  - `att_step`, `rel_step` and `sample_en` are ignored; ATTACK/RELEASE are never entered.

## Structure
- Shared package `notebank_pkg`:
  - voice state enum;
  - `DUTY_W`=8;
  - saturation helper function.
- Sub-module `notebank_voice`: phase counter, PWM compare, FSM and envelope. Instantiated `VOICES` times in a generate loop.
- The top level holds the mixer/saturation and the output registers.

## Test plan
- VOICES=1, period=100, duty=128, amp=1000, `ENVELOPE_EN` undefined, `note_on` → `audio_out` alternates +32000/−32000 (amp × 2^5) for 50/50 cycles; `note_off` → 0 and `done` pulses once.
- `ENVELOPE_EN`, att_step=300, amp=1000, `sample_en` every 4 clk → `env` 300, 600, 900, 1000, then SUSTAIN. rel_step=400 from 1000 → 600, 200, 0, then IDLE and one `done` pulse.
- Simultaneous `note_on`+`note_off` on an IDLE voice → ATTACK; on a RELEASE voice at `env`=500 → ATTACK continuing from 500.
- VOICES=4, all voices sustaining, amp=2^18−1, all `sqon` high → `audio_out` saturates at 8388607; with all low → −8388608.
- period=1 and period=0 → `phase` stays 0 and `sqon`=0 (duty<256), so the output is the steady −`env`; duty=0 → `thr`=0, constant negative.
- `rst` during ATTACK of voice 2 → next cycle: all outputs 0, `active`=0, no `done` pulse.
